lc3_sext: RTL and testbench



---
 rtl/lc3_sext.sv | 64 ++++++
 tb/tb_lc3_sext.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lc3_sext.sv
// LC-3 sign-extension unit: widens in[N-1:0] to 16 bits, with a registered, valid-qualified copy.
// Optional zero-extension select is compiled in with LC3_SEXT_ZEXT_EN.
module lc3_sext #(
  parameter int N = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_valid,
`ifdef LC3_SEXT_ZEXT_EN
  input  logic        zext,
`endif
  output logic [15:0] out,
  output logic        neg,
  output logic [15:0] out_q,
  output logic        out_valid
);

  logic        fill;
  logic [15:0] data_d, data_q;
  logic        vld_d, vld_q;
  logic        unused_hi;

  // in[15:N] is deliberately ignored; fold it here so it is not flagged as dangling.
  assign unused_hi = ^in;

  assign neg = in[N-1];

`ifdef LC3_SEXT_ZEXT_EN
  assign fill = in[N-1] & ~zext;
`else
  assign fill = in[N-1];
`endif

  generate
    if (N < 1 || N > 16) begin : g_bad_n
      $error("lc3_sext: N must be in 1..16");
    end else if (N == 16) begin : g_full
      assign out = in;
    end else begin : g_ext
      assign out = {{(16-N){fill}}, in[N-1:0]};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    vld_d  = in_valid;
    if (in_valid) data_d = out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_q     = data_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_lc3_sext.sv
// Self-checking bench for lc3_sext: directed test-plan steps plus randomized traffic
// against an arithmetic reference model, across several field widths.
module tb_lc3_sext;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        iv;
  logic        zx;
  int          tests = 0;
  int          fails = 0;

  logic [15:0] o8, q8, o4, q4, o5, q5, o16, q16, o1, q1;
  logic        n8, v8, n4, v4, n5, v5, n16, v16, n1, v1;

  logic [15:0] exp_q;
  logic        exp_v;

  always #5 clk = ~clk;

`ifdef LC3_SEXT_ZEXT_EN
  `define ZX_PORT .zext(zx),
  localparam bit ZEN = 1'b1;
`else
  `define ZX_PORT
  localparam bit ZEN = 1'b0;
`endif

  lc3_sext #(.N(8))  u8  (.clk(clk), .rst(rst), .in(din), .in_valid(iv), `ZX_PORT
                          .out(o8),  .neg(n8),  .out_q(q8),  .out_valid(v8));
  lc3_sext #(.N(4))  u4  (.clk(clk), .rst(rst), .in(din), .in_valid(iv), `ZX_PORT
                          .out(o4),  .neg(n4),  .out_q(q4),  .out_valid(v4));
  lc3_sext #(.N(5))  u5  (.clk(clk), .rst(rst), .in(din), .in_valid(iv), `ZX_PORT
                          .out(o5),  .neg(n5),  .out_q(q5),  .out_valid(v5));
  lc3_sext #(.N(16)) u16 (.clk(clk), .rst(rst), .in(din), .in_valid(iv), `ZX_PORT
                          .out(o16), .neg(n16), .out_q(q16), .out_valid(v16));
  lc3_sext #(.N(1))  u1  (.clk(clk), .rst(rst), .in(din), .in_valid(iv), `ZX_PORT
                          .out(o1),  .neg(n1),  .out_q(q1),  .out_valid(v1));

  // Reference: take the field as an unsigned number, subtract 2^n when its top bit is set.
  function automatic logic [15:0] ref_ext(int n, logic [15:0] x, bit z);
    int v;
    v = int'(x) % (1 << n);
    if (!z && v >= (1 << (n - 1))) v = v - (1 << n);
    return v[15:0];
  endfunction

  function automatic logic ref_neg(int n, logic [15:0] x);
    return ((int'(x) / (1 << (n - 1))) % 2) == 1;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    bit z;
    z = ZEN && zx;
    chk("out8",  o8,  ref_ext(8,  din, z));
    chk("neg8",  {15'd0, n8},  {15'd0, ref_neg(8,  din)});
    chk("out4",  o4,  ref_ext(4,  din, z));
    chk("neg4",  {15'd0, n4},  {15'd0, ref_neg(4,  din)});
    chk("out5",  o5,  ref_ext(5,  din, z));
    chk("out16", o16, din);
    chk("neg16", {15'd0, n16}, {15'd0, ref_neg(16, din)});
    chk("out1",  o1,  ref_ext(1,  din, z));
    chk("neg1",  {15'd0, n1},  {15'd0, ref_neg(1,  din)});
  endtask

  // Apply inputs, check the combinational side, clock once, check the registered side.
  task automatic step(logic r, logic [15:0] d, logic v, logic z);
    rst = r; din = d; iv = v; zx = z;
    #1;
    chk_comb();
    if (r) begin
      exp_q = '0; exp_v = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_q = ref_ext(8, d, ZEN && z);
    end
    @(posedge clk); #1;
    chk("out_q8", q8, exp_q);
    chk("out_valid8", {15'd0, v8}, {15'd0, exp_v});
  endtask

  initial begin
    rst = 1'b1; din = '0; iv = 1'b0; zx = 1'b0;
    exp_q = '0; exp_v = 1'b0;
    @(posedge clk); #1;
    chk("rst_q", q8, 16'h0000);
    chk("rst_v", {15'd0, v8}, 16'd0);
    rst = 1'b0;

    // Directed combinational values from the test plan.
    din = 16'h0080; #0; #1;
    chk("d_n8_m128", o8, 16'hFF80);
    chk("d_neg8_1", {15'd0, n8}, 16'd1);
    din = 16'h007F; #1;
    chk("d_n8_127", o8, 16'h007F);
    chk("d_neg8_0", {15'd0, n8}, 16'd0);
    din = 16'h0008; #1;
    chk("d_n4_m8", o4, 16'hFFF8);
    din = 16'h0007; #1;
    chk("d_n4_7", o4, 16'h0007);
    din = 16'hABC5; #1;
    chk("d_n4_hi_ign", o4, 16'h0005);
    din = 16'hFFF0; #1;
    chk("d_n5_neg", o5, 16'hFFF0);
    din = 16'h0001; #1;
    chk("d_n1_one", o1, 16'hFFFF);
    din = 16'hFFFE; #1;
    chk("d_n1_zero", o1, 16'h0000);
    din = 16'h8123; #1;
    chk("d_n16_pass", o16, 16'h8123);
`ifdef LC3_SEXT_ZEXT_EN
    din = 16'h0080; zx = 1'b1; #1;
    chk("d_zext1", o8, 16'h0080);
    chk("d_zext_neg", {15'd0, n8}, 16'd1);
    zx = 1'b0; #1;
    chk("d_zext0", o8, 16'hFF80);
`endif

    // Registered path sequence.
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0081, 1'b1, 1'b0);
    chk("d_q_ff81", q8, 16'hFF81);
    step(1'b0, 16'h0011, 1'b0, 1'b0);
    chk("d_q_hold", q8, 16'hFF81);
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    chk("d_q_rstwins", q8, 16'h0000);
    step(1'b0, 16'h007E, 1'b1, 1'b0);
    chk("d_q_after_rst", q8, 16'h007E);
    step(1'b0, 16'h00F0, 1'b1, 1'b0);
    chk("d_q_b2b", q8, 16'hFFF0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
